// File: rtl/pipelined_subtractor_pkg.sv
// Shared geometry helpers and stage control record for pipelined_subtractor.
package pipelined_subtractor_pkg;

    // Valid flag plus the borrow handed to the next slice.
    typedef struct packed {
        logic valid;
        logic borrow;
    } stage_ctl_t;

    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? width / stages : 0;
    endfunction

    function automatic bit geometry_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational slice full subtractor: {bo, d} = x - y - bi.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    assign {bo, d} = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};

endmodule

// File: rtl/pipelined_subtractor.sv
// diff = a - b - bin over STAGES registered slices, valid/ready with back-pressure.
// SUB_SAT_EN: clamp diff to 0 on final borrow (unsigned saturation), same latency.
module pipelined_subtractor
    import pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_subtractor: WIDTH must be a non-zero multiple of STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO   = (k + 1) * SW;
        localparam bit LAST = (k == STAGES - 1);

        stage_ctl_t    ctl;
        logic [LO-1:0] dlo;
        logic [LO-1:0] dlo_nxt;
        logic [SW-1:0] x, y, d;
        logic          bi, bo, vld_in, ld;

        sub_slice #(.W(SW)) u_slice (.x(x), .y(y), .bi(bi), .d(d), .bo(bo));

        if (k == 0) begin : g_src
            assign x       = a[SW-1:0];
            assign y       = b[SW-1:0];
            assign bi      = bin;
            assign vld_in  = in_valid;
            assign dlo_nxt = d;
        end else begin : g_src
            assign x       = g_st[k-1].g_hi.a_hi[SW-1:0];
            assign y       = g_st[k-1].g_hi.b_hi[SW-1:0];
            assign bi      = g_st[k-1].ctl.borrow;
            assign vld_in  = g_st[k-1].ctl.valid;
            assign dlo_nxt = {d, g_st[k-1].dlo};
        end

        // A stage may load when empty or when the stage ahead is moving.
        if (LAST) begin : g_ld
            assign ld = !ctl.valid || out_ready;
        end else begin : g_ld
            assign ld = !ctl.valid || g_st[k+1].ld;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctl <= '0;
                dlo <= '0;
            end else if (ld) begin
                ctl.valid <= vld_in;
                if (vld_in) begin
                    ctl.borrow <= bo;
`ifdef SUB_SAT_EN
                    dlo <= (LAST && bo) ? '0 : dlo_nxt;
`else
                    dlo <= dlo_nxt;
`endif
                end
            end
        end

        // Unprocessed high operand bits travel alongside the partial result.
        if (!LAST) begin : g_hi
            localparam int HI = WIDTH - LO;
            logic [HI-1:0] a_hi, b_hi, a_nxt, b_nxt;

            if (k == 0) begin : g_src
                assign a_nxt = a[WIDTH-1:SW];
                assign b_nxt = b[WIDTH-1:SW];
            end else begin : g_src
                assign a_nxt = g_st[k-1].g_hi.a_hi[HI+SW-1:SW];
                assign b_nxt = g_st[k-1].g_hi.b_hi[HI+SW-1:SW];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (ld && vld_in) begin
                    a_hi <= a_nxt;
                    b_hi <= b_nxt;
                end
            end
        end
    end

    assign in_ready  = g_st[0].ld;
    assign out_valid = g_st[STAGES-1].ctl.valid;
    assign bout      = g_st[STAGES-1].ctl.borrow;
    assign diff      = g_st[STAGES-1].dlo;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed table plus streaming scoreboard bench for pipelined_subtractor (WIDTH=32, STAGES=4).
module tb_pipelined_subtractor;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d_wrap;
        logic [31:0] d_sat;
        logic        bo;
    } vec_t;

    vec_t             vecs[8];
    logic [WIDTH:0]   sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic bi);
        logic [WIDTH:0] r;
        r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
`ifdef SUB_SAT_EN
        if (r[WIDTH]) r[WIDTH-1:0] = '0;
`endif
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        int sel;
        sel = $urandom_range(7);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return $urandom;
    endfunction

    task automatic stream(input int nops, input int pv, input int pr, input int st_lo,
                          input int st_hi, output int cycles, output bit saw_block);
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [WIDTH:0] hold_val = '0;
        logic [WIDTH:0] e;
        saw_block = 1'b0;
        while (recv < nops && cyc < nops * 20 + 100) begin
            @(negedge clk);
            out_ready = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : ($urandom_range(99) < pr);
            in_valid  = (sent < nops) && ($urandom_range(99) < pv);
            a   = pick_operand();
            b   = pick_operand();
            bin = $urandom_range(1);
            #1;
            if (held) chk("stall_hold", {30'd0, out_valid, bout, diff}, {30'd0, 1'b1, hold_val});
            held     = out_valid && !out_ready;
            hold_val = {bout, diff};
            if (out_valid && out_ready) begin
                chk("queue_nonempty", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("stream_result", {31'd0, bout, diff}, {31'd0, e});
                end
                recv++;
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) begin
                sbq.push_back(model(a, b, bin));
                sent++;
            end
            cyc++;
        end
        cycles = cyc;
        chk("stream_complete", 64'(recv), 64'(nops));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int cycles;
        int seen;
        bit blk;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFE, 32'h0000_FFFE, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 32'hFFFE_0001, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors: result and exact latency
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
`ifdef SUB_SAT_EN
            chk($sformatf("vec%0d_diff", i), 64'(diff), 64'(vecs[i].d_sat));
`else
            chk($sformatf("vec%0d_diff", i), 64'(diff), 64'(vecs[i].d_wrap));
`endif
            chk($sformatf("vec%0d_bout", i), 64'(bout), 64'(vecs[i].bo));
        end
        @(negedge clk);
        out_ready = 1'b0;

        // Mid-stream reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 10); b = 32'd1; bin = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", 64'(diff), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_stale_after_reset", 64'(seen), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Back-pressure window
        stream(10, 100, 100, 5, 12, cycles, blk);
        chk("backpressure_in_ready_drop", 64'(blk), 64'd1);

        // Full throughput
        stream(40, 100, 100, -1, -1, cycles, blk);
        chk("throughput_cycles", 64'(cycles), 64'(40 + STAGES));
        chk("throughput_no_block", 64'(blk), 64'd0);

        // Random handshakes
        stream(3000, 70, 70, -1, -1, cycles, blk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
